// File: rtl/fifo_singleclock_multi_rd_port_fwft.sv
// fifo_singleclock_multi_rd_port_fwft
//   Synchronous first-word-fall-through FIFO with NPORTS independent read ports
//   that share one storage array. Every word is delivered to every enabled port.
//   A port can be removed at run time through port_en, so a dead path no longer
//   holds back the writer.
//
//   clk, rst    clock, synchronous active-high reset
//   din, wr_en  write side; full means the write is dropped this cycle
//   prog_full   fill level >= PROG_FULL (tied 0 when PROG_FULL == 0)
//   port_en     per-port enable; a disabled port is excluded from fill accounting
//   dout        per-port head word, valid when empty[i] == 0
//   rd_en       per-port pop of dout[i]
//   empty       per-port "dout[i] invalid"
//   level       occupancy seen by the slowest enabled port

// fifo_mrp_rd_port
//   One read port: a pointer into the shared array plus a one-word output
//   register. rd_ptr_q tracks the word in the output register, so occupancy
//   includes that word and its storage slot stays reserved until it is popped.
//
//   en_rise            port is being (re)enabled at this edge
//   wr_ptr/_nxt/_vis   current, next and one-cycle-delayed write pointer
//   rd_en, rd_data     pop request; storage word at rd_idx
//   dout, empty, occ   head word, head invalid, per-port occupancy
module fifo_mrp_rd_port #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 32,
  parameter int PW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_rise,
  input  logic [PW-1:0]    wr_ptr,
  input  logic [PW-1:0]    wr_ptr_nxt,
  input  logic [PW-1:0]    wr_vis,
  input  logic             rd_en,
  input  logic [WIDTH-1:0] rd_data,
  output logic [PW-2:0]    rd_idx,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic [PW-1:0]    occ
);

  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic             vld_q, vld_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic [PW-1:0]    fetch_ptr, avail;
  logic             pop, load;

  always_comb begin
    pop       = rd_en & vld_q;
    // next word to prefetch sits just past the one held in the output register
    fetch_ptr = rd_ptr_q + PW'(vld_q);
    // availability is judged on the delayed write pointer, which gives the
    // two-edge write-to-dout latency. Right after a re-enable the delayed
    // pointer can trail fetch_ptr by one, so only 1..DEPTH counts as data.
    avail     = wr_vis - fetch_ptr;
    load      = (!vld_q || pop) && (avail != '0) && (avail <= PW'(DEPTH));
    rd_ptr_d  = rd_ptr_q + PW'(pop);
    vld_d     = load || (vld_q && !pop);
    dout_d    = load ? rd_data : dout_q;
    if (en_rise) begin
      // resynchronise to the post-write pointer: a write at this edge is not delivered
      rd_ptr_d = wr_ptr_nxt;
      vld_d    = 1'b0;
      dout_d   = dout_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      vld_q    <= 1'b0;
      dout_q   <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      vld_q    <= vld_d;
      dout_q   <= dout_d;
    end
  end

  assign rd_idx = fetch_ptr[PW-2:0];
  assign dout   = dout_q;
  assign empty  = !vld_q;
  assign occ    = wr_ptr - rd_ptr_q;

endmodule

module fifo_singleclock_multi_rd_port_fwft #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 32,
  parameter int NPORTS    = 2,
  parameter int PROG_FULL = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [WIDTH-1:0]             din,
  input  logic                         wr_en,
  output logic                         full,
  output logic                         prog_full,
  input  logic [NPORTS-1:0]            port_en,
  output logic [NPORTS-1:0][WIDTH-1:0] dout,
  input  logic [NPORTS-1:0]            rd_en,
  output logic [NPORTS-1:0]            empty,
  output logic [$clog2(DEPTH):0]       level
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     wr_vis_q, wr_vis_d;
  logic [NPORTS-1:0] en_q, en_d;
  logic [WIDTH-1:0]  mem_q [DEPTH];

  logic [NPORTS-1:0][PW-1:0]    occ;
  logic [NPORTS-1:0][AW-1:0]    rd_idx;
  logic [NPORTS-1:0][WIDTH-1:0] rd_data;
  logic [NPORTS-1:0]            en_rise;
  logic [PW-1:0]                level_c;
  logic                         wr_acc;

  always_comb begin
    // slowest enabled port sets the fill level; the registered enable makes a
    // dropped port leave the accounting one cycle after port_en falls
    level_c = '0;
    for (int i = 0; i < NPORTS; i++)
      if (en_q[i] && (occ[i] > level_c)) level_c = occ[i];
  end

  assign full    = (level_c == PW'(DEPTH));
  assign level   = level_c;
  assign wr_acc  = wr_en && !full;
  assign en_rise = port_en & ~en_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(wr_acc);
    wr_vis_d = wr_ptr_q;
    en_d     = port_en;
  end

  generate
    if (PROG_FULL == 0) begin : g_no_pf
      assign prog_full = 1'b0;
    end else begin : g_pf
      assign prog_full = (level_c >= PW'(PROG_FULL));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      wr_vis_q <= '0;
      // seed from the live enables so ports enabled across reset see the first write
      en_q     <= port_en;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      wr_vis_q <= wr_vis_d;
      en_q     <= en_d;
    end
  end

  // storage needs no reset: pointers alone define what is valid
  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

  genvar g;
  generate
    for (g = 0; g < NPORTS; g++) begin : g_port
      assign rd_data[g] = mem_q[rd_idx[g]];
      fifo_mrp_rd_port #(.WIDTH(WIDTH), .DEPTH(DEPTH), .PW(PW)) u_port (
        .clk        (clk),
        .rst        (rst),
        .en_rise    (en_rise[g]),
        .wr_ptr     (wr_ptr_q),
        .wr_ptr_nxt (wr_ptr_d),
        .wr_vis     (wr_vis_q),
        .rd_en      (rd_en[g]),
        .rd_data    (rd_data[g]),
        .rd_idx     (rd_idx[g]),
        .dout       (dout[g]),
        .empty      (empty[g]),
        .occ        (occ[g])
      );
    end
  endgenerate

endmodule

// File: tb/tb_fifo_singleclock_multi_rd_port_fwft.sv
// Directed bench for fifo_singleclock_multi_rd_port_fwft (WIDTH 8, DEPTH 32,
// NPORTS 2, PROG_FULL 24). Inputs change 1 time unit after the rising edge and
// outputs are checked there too, well away from the next edge.
module tb_fifo_singleclock_multi_rd_port_fwft;
  localparam int W  = 8;
  localparam int D  = 32;
  localparam int N  = 2;
  localparam int PF = 24;
  localparam int PW = $clog2(D) + 1;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [W-1:0]            din;
  logic                    wr_en;
  logic                    full, prog_full;
  logic [N-1:0]            port_en, rd_en, empty;
  logic [N-1:0][W-1:0]     dout;
  logic [PW-1:0]           level;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  fifo_singleclock_multi_rd_port_fwft #(.WIDTH(W), .DEPTH(D), .NPORTS(N), .PROG_FULL(PF)) dut (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .wr_en     (wr_en),
    .full      (full),
    .prog_full (prog_full),
    .port_en   (port_en),
    .dout      (dout),
    .rd_en     (rd_en),
    .empty     (empty),
    .level     (level)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [W-1:0] v);
    din   = v;
    wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1; din = '0; wr_en = 1'b0; rd_en = '0; port_en = 2'b11;
    tick(); tick();
    chk("rst_empty", 32'(empty), 32'h3);
    chk("rst_full",  32'(full), 32'h0);
    chk("rst_level", 32'(level), 32'h0);
    chk("rst_pf",    32'(prog_full), 32'h0);
    chk("rst_dout",  32'(dout), 32'h0);
    rst = 1'b0;

    // 1) single word latency: written at edge E, visible from E+2
    wr(8'hA5);
    chk("t1_e1_empty", 32'(empty), 32'h3);
    tick();
    chk("t1_e2_empty", 32'(empty), 32'h3);
    tick();
    chk("t1_e3_empty", 32'(empty), 32'h0);
    chk("t1_dout0", 32'(dout[0]), 32'hA5);
    chk("t1_dout1", 32'(dout[1]), 32'hA5);
    chk("t1_level", 32'(level), 32'h1);
    rd_en = 2'b11; tick(); rd_en = '0;
    chk("t1_pop_empty", 32'(empty), 32'h3);
    chk("t1_pop_level", 32'(level), 32'h0);
    chk("t1_hold_dout", 32'(dout[0]), 32'hA5);

    // 2) fill to full, extra write dropped
    for (int k = 0; k < 31; k++) wr(W'(k));
    chk("t2_31_full", 32'(full), 32'h0);
    wr(8'd31);
    chk("t2_full", 32'(full), 32'h1);
    chk("t2_level", 32'(level), 32'd32);
    chk("t2_pf", 32'(prog_full), 32'h1);
    wr(8'hFF);
    chk("t2_ovf_level", 32'(level), 32'd32);
    tick();

    // 3) port 0 drains everything, port 1 holds the FIFO full
    for (int k = 0; k < 32; k++) begin
      chk("t3_p0_empty", 32'(empty[0]), 32'h0);
      chk("t3_p0_data", 32'(dout[0]), 32'(k));
      rd_en = 2'b01; tick();
    end
    rd_en = '0;
    chk("t3_p0_done", 32'(empty[0]), 32'h1);
    chk("t3_level", 32'(level), 32'd32);
    chk("t3_full", 32'(full), 32'h1);
    for (int k = 0; k < 32; k++) begin
      chk("t3_p1_data", 32'(dout[1]), 32'(k));
      rd_en = 2'b10; tick();
      if (k == 0) begin
        chk("t3_p1_full", 32'(full), 32'h0);
        chk("t3_p1_level", 32'(level), 32'd31);
      end
    end
    rd_en = '0;
    chk("t3_all_empty", 32'(empty), 32'h3);
    chk("t3_end_level", 32'(level), 32'h0);

    // 4) drop and re-enable port 1
    for (int k = 0; k < 32; k++) wr(W'(8'h40 + k));
    tick();
    chk("t4_full", 32'(full), 32'h1);
    for (int k = 0; k < 8; k++) begin
      chk("t4_p0_data", 32'(dout[0]), 32'(8'h40 + k));
      rd_en = 2'b01; tick();
    end
    rd_en = '0;
    chk("t4_still_full", 32'(full), 32'h1);
    port_en = 2'b01; tick();
    chk("t4_dis_level", 32'(level), 32'd24);
    chk("t4_dis_full", 32'(full), 32'h0);
    chk("t4_dis_p1_data", 32'(dout[1]), 32'h40);
    chk("t4_dis_p1_empty", 32'(empty[1]), 32'h0);
    for (int k = 0; k < 8; k++) wr(W'(8'h80 + k));
    chk("t4_p0_full", 32'(full), 32'h1);
    port_en = 2'b11; tick();
    chk("t4_en_empty1", 32'(empty[1]), 32'h1);
    chk("t4_en_level", 32'(level), 32'd32);
    for (int k = 0; k < 4; k++) begin
      chk("t4_p0_data2", 32'(dout[0]), 32'(8'h48 + k));
      rd_en = 2'b01; tick();
    end
    rd_en = '0;
    chk("t4_level28", 32'(level), 32'd28);
    chk("t4_nfull", 32'(full), 32'h0);
    wr(8'hC3);
    chk("t4_new_e1", 32'(empty[1]), 32'h1);
    tick();
    chk("t4_new_e2", 32'(empty[1]), 32'h1);
    tick();
    chk("t4_new_e3", 32'(empty[1]), 32'h0);
    chk("t4_new_data", 32'(dout[1]), 32'hC3);
    chk("t4_level29", 32'(level), 32'd29);

    // 5) prog_full threshold at 24
    rst = 1'b1; tick(); rst = 1'b0;
    for (int k = 0; k < 23; k++) wr(W'(k));
    chk("t5_23_pf", 32'(prog_full), 32'h0);
    chk("t5_23_level", 32'(level), 32'd23);
    wr(8'd23);
    chk("t5_24_pf", 32'(prog_full), 32'h1);
    tick();
    rd_en = 2'b11; tick(); rd_en = '0;
    chk("t5_rd_pf", 32'(prog_full), 32'h0);
    chk("t5_rd_level", 32'(level), 32'd23);
    chk("t5_rd_dout", 32'(dout), 32'h0101);

    // 6) reset mid-operation with writes and reads in flight
    wr_en = 1'b1; din = 8'h77; rd_en = 2'b11; rst = 1'b1;
    tick();
    wr_en = 1'b0; rd_en = '0; rst = 1'b0;
    chk("t6_empty", 32'(empty), 32'h3);
    chk("t6_level", 32'(level), 32'h0);
    chk("t6_full", 32'(full), 32'h0);
    chk("t6_pf", 32'(prog_full), 32'h0);
    chk("t6_dout", 32'(dout), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
